// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter that sequences the shared 8-bit
// combinational ALU. The winning port's operands are registered into the ALU,
// held for SETTLE_CYCLES edges so the ALU output settles, then the result and
// flags are captured and a one-cycle done pulse goes to the granted port.
module alu_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic [2:0] f0,
  input  logic [2:0] f1,
  output logic [1:0] gnt,
  output logic       done0,
  output logic       done1,
  output logic [7:0] res_w,
  output logic       res_c,
  output logic       res_z,
  output logic       busy,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_f,
  input  logic [7:0] alu_w,
  input  logic       alu_c,
  input  logic       alu_z
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       port_q, port_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [2:0] alu_f_q, alu_f_d;
  logic [7:0] res_w_q, res_w_d;
  logic       res_c_q, res_c_d;
  logic       res_z_q, res_z_d;

  logic       anyReq;
  logic       winner;

  // Round-robin pick: on a tie the port not served last wins, otherwise the sole requester.
  always_comb begin
    anyReq = req0 | req1;
    winner = (req0 && req1) ? ~last_q : req1;
  end

  // State and datapath registers; reset leaves last-served at port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      alu_a_q <= 8'd0;
      alu_b_q <= 8'd0;
      alu_f_q <= 3'd0;
      res_w_q <= 8'd0;
      res_c_q <= 1'b0;
      res_z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      port_q  <= port_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_f_q <= alu_f_d;
      res_w_q <= res_w_d;
      res_c_q <= res_c_d;
      res_z_q <= res_z_d;
    end
  end

  // Next state: operands are latched only at the grant edge, results only at the final settle edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    port_d  = port_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_f_d = alu_f_q;
    res_w_d = res_w_q;
    res_c_d = res_c_q;
    res_z_d = res_z_q;
    case (state_q)
      ST_IDLE: begin
        if (anyReq) begin
          port_d  = winner;
          alu_a_d = winner ? a1 : a0;
          alu_b_d = winner ? b1 : b0;
          alu_f_d = winner ? f1 : f0;
          cnt_d   = 4'd0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          res_w_d = alu_w;
          res_c_d = alu_c;
          res_z_d = alu_z;
          last_d  = port_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: grant and busy cover WAIT and DONE; done goes only to the port holding the grant.
  always_comb begin
    busy  = (state_q != ST_IDLE);
    gnt   = busy ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    done0 = (state_q == ST_DONE) && !port_q;
    done1 = (state_q == ST_DONE) && port_q;
    alu_a = alu_a_q;
    alu_b = alu_b_q;
    alu_f = alu_f_q;
    res_w = res_w_q;
    res_c = res_c_q;
    res_z = res_z_q;
  end

endmodule
